// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half-adder cells and an OR of their carries.
// The half-adder cell is included here so the slice builds standalone.
module HalfAdder (
  input  logic a,
  input  logic b,
  output logic carry,
  output logic sum
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic sum
);

  logic c1_s;
  logic s1_s;
  logic c2_s;

  HalfAdder u_ha_ab (
    .a     (a),
    .b     (b),
    .carry (c1_s),
    .sum   (s1_s)
  );

  HalfAdder u_ha_cin (
    .a     (s1_s),
    .b     (cin),
    .carry (c2_s),
    .sum   (sum)
  );

  assign cout = c1_s | c2_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// with ready/valid handshakes on operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             fa_sum_s;
  logic             fa_cout_s;

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .cout (fa_cout_s),
    .sum  (fa_sum_s)
  );

  // Control FSM, operand/sum shift registers and registered handshake outputs.
  // The visible sum/cout are separate registers so the shifting partial sum
  // never leaks out, and the previous result stays visible through IDLE/BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            carry_r    <= cin;
            cnt_r      <= '0;
            state_r    <= BUSY;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        BUSY: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
          carry_r  <= fa_cout_s;
          if (cnt_r == CNT_LAST) begin
            cnt_r       <= '0;
            sum_r       <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
            cout_r      <= fa_cout_s;
            state_r     <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, scoreboard queue,
// plus hand-written backpressure, ignored-request and mid-job reset sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp;
  int n_fail;

  logic [W:0] sb_q[$];

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W:0]   vexp;
  } vec_t;

  vec_t vecs[8];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one job, check its timing, optionally stall the consumer and/or
  // pulse in_valid during BUSY, then pop the scoreboard at the handoff.
  task automatic run_job(input logic [W-1:0] ja, input logic [W-1:0] jb, input logic jc,
                         input int hold, input int pulse_at);
    int lat;
    int busy_ok;
    int stable_ok;
    logic [W:0] exp;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = ja;
    b = jb;
    cin = jc;
    in_valid = 1'b1;
    sb_q.push_back({1'b0, ja} + {1'b0, jb} + {{W{1'b0}}, jc});
    @(posedge clk);
    #1 in_valid = 1'b0;
    busy_ok = 0;
    lat = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      lat++;
      if (busy && !out_valid && !in_ready) busy_ok++;
      if (i == pulse_at) begin
        in_valid = 1'b1;
        a = 8'h11;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("busy_cycles", busy_ok, W);
    @(negedge clk);
    lat++;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat - 1, W);
    check("busy_low_done", {31'd0, busy}, 32'd0);
    exp = sb_q[0];
    stable_ok = 0;
    for (int h = 0; h < hold; h++) begin
      if (out_valid && !in_ready && sum == exp[W-1:0] && cout == exp[W]) stable_ok++;
      @(negedge clk);
    end
    if (hold > 0) check("hold_stable", stable_ok, hold);
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      exp = sb_q.pop_front();
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
      check("cout", {31'd0, cout}, {31'd0, exp[W]});
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handoff", {30'd0, in_ready, out_valid}, 32'd2);
    check("sum_kept_idle", {23'd0, cout, sum}, {23'd0, exp});
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 9'h100};
    vecs[5] = '{8'hA5, 8'h5A, 1'b0, 9'h0FF};
    vecs[6] = '{8'hC3, 8'h3D, 1'b1, 9'h101};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 9'h002};

    #2;
    check("rst_outputs", {20'd0, in_ready, out_valid, busy, cout, sum}, {20'd0, 4'b1000, 8'h00});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors: expected value from the table cross-checked against a + b + cin.
    for (int v = 0; v < 8; v++) begin
      check("table_entry", {23'd0, vecs[v].vexp},
            {23'd0, {1'b0, vecs[v].va} + {1'b0, vecs[v].vb} + {8'd0, vecs[v].vc}});
      run_job(vecs[v].va, vecs[v].vb, vecs[v].vc, 0, -1);
    end

    // Backpressure: result held stable for 5 cycles.
    run_job(8'h5A, 8'h25, 1'b0, 5, -1);

    // in_valid pulsed during BUSY must be ignored.
    run_job(8'h03, 8'h04, 1'b0, 0, 3);
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid || busy) extra++;
      end
      check("no_second_result", extra, 0);
      check("queue_drained", sb_q.size(), 0);
    end

    // Reset asserted at cnt=4 of a job.
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    @(negedge clk);
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {20'd0, in_ready, out_valid, busy, cout, sum}, {20'd0, 4'b1000, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    begin
      int rose;
      rose = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) rose++;
      end
      check("no_result_after_rst", rose, 0);
    end
    run_job(8'h80, 8'h80, 1'b0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder: accepts two operands plus carry-in, adds one bit per clock (LSB first) through a single full-adder cell and a carry flip-flop, then presents the sum and carry-out.
- Sits downstream of the team's existing HalfAdder cell and consumes its carry/sum outputs: two HalfAdder instances form the per-bit full adder inside this block.
- Ready/valid on both sides, so it can be dropped between register stages in the datapath exercises.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A, sampled on acceptance.
- b  input  WIDTH  operand B, sampled on acceptance.
- cin  input  1  carry-in, sampled on acceptance.
- out_valid  output  1  sum/cout valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in BUSY.

Behaviour:
- Reset (async, immediate): state=IDLE, shift regs, carry reg and bit counter cleared. in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to BUSY.
  - Otherwise stay.
- BUSY, each edge:
  - Full adder on (a_sh[0], b_sh[0], carry). Stage 1: HalfAdder(a0,b0) gives c1,s1. Stage 2: HalfAdder(s1,carry) gives c2,s. New carry = c1|c2.
  - sum_sh shifts right with s into MSB. a_sh and b_sh shift right. carry<=new carry. cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: go to DONE. cout<=new carry.
  - in_valid is ignored in BUSY; in_ready=0.
- DONE:
  - out_valid=1; sum=sum_sh and cout are held stable while out_valid=1 && out_ready=0.
  - On edge with out_ready=1: go to IDLE, out_valid falls.
  - No acceptance in DONE (in_ready=0), so a new operand is taken at the earliest one cycle after result handoff.
- Latency: acceptance edge T0. Bits are processed at edges T1..TWIDTH. out_valid is high after edge TWIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum initiation interval: WIDTH+2 cycles (accept, WIDTH bit cycles, handoff).
- Arithmetic: unsigned. {cout,sum} == a+b+cin exactly (WIDTH+1 bits). Wrap-around is expressed only through cout; no saturation.
- Counter: width $clog2(WIDTH); never exceeds WIDTH-1.
- sum/cout outputs: registered. Last value remains visible in IDLE until the next result overwrites it; only reset clears them.
- Reset mid-BUSY or mid-DONE: aborts immediately, no partial result emitted, returns to IDLE state above.
- in_valid and out_ready both high in DONE: only out_ready acts; the operand is not accepted until the IDLE cycle.

Decomposition:
- Shared package serial_adder_pkg: state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the WIDTH legality range constants.
- Natural sub-module: full_adder (a, b, cin -> cout, sum), built from two HalfAdder instances plus an OR. Instantiated once in serial_adder.

Test Plan (WIDTH=8):
- a=0x0F, b=0x01, cin=0 → out_valid exactly 8 cycles after acceptance; sum=0x10, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1 (wrap-around).
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1; a=0x00, b=0x00, cin=0 → sum=0x00, cout=0.
- Backpressure: a=0x5A, b=0x25, hold out_ready=0 for 5 cycles after out_valid → sum=0x7F, cout=0 stable throughout; in_ready stays 0; release → IDLE next cycle.
- in_valid pulsed with a=0x11 during BUSY of an a=0x03, b=0x04 job → ignored; result sum=0x07; no second result appears.
- Assert rst for 1 cycle at cnt=4 of a=0xAA, b=0x55 → immediate IDLE, out_valid never rises, sum=0, cout=0. Next job a=0x80, b=0x80 → sum=0x00, cout=1.
